sr_pulse_driver: RTL and testbench
==================================

// Module: sr_pulse_driver
// PURPOSE
//  Command-side driver for a bank of SR flip-flops: converts write requests (channel, value) into
//  clean set/reset pulses on per-channel s/r lines. Guarantees s and r are never both high,
//  enforces a minimum pulse width and a dead gap between commands, and tracks each flop's state.
//  Sits between control logic (valid/ready requester) and the SR storage bank.
// PARAMETERS
//  N_CH          4  number of SR channels driven (>=1)
//  PULSE_CYCLES  2  cycles s or r is held high per command (>=1)
//  GAP_CYCLES    1  all-low cycles after each pulse before next accept (>=0)
// PORTS
//  clk        in   1         clock, all logic on rising edge
//  rst_n      in   1         synchronous reset, active-low
//  req_valid  in   1         command valid
//  req_ready  out  1         command accepted when req_valid & req_ready
//  req_ch     in   CW        target channel, CW = max(1,$clog2(N_CH))
//  req_val    in   1         1 = set channel, 0 = reset channel
//  s          out  N_CH      set lines to SR bank
//  r          out  N_CH      reset lines to SR bank
//  state_q    out  N_CH      tracked flop state
//  busy       out  1         high outside IDLE
//  done       out  1         one-cycle pulse on command completion
//  err        out  1         one-cycle pulse: out-of-range channel accepted
// BEHAVIOUR
//  Reset (rst_n=0 at edge): s=0, r=0, state_q=0, busy=0, done=0, err=0, req_ready=0; FSM->IDLE.
//  req_ready = (FSM==IDLE) & rst_n; requester may hold req_valid; fields sampled at accept edge only.
//  FSM: IDLE -accept-> PULSE -PULSE_CYCLES done-> GAP (skipped if GAP_CYCLES==0) -> IDLE.
//  Timing, accept at edge E0: PULSE in cycles 1..P; GAP in cycles P+1..P+G; cycle P+G+1 is IDLE
//   with done=1 and req_ready=1 (back-to-back accept allowed there). Throughput 1 cmd / P+G+1 cycles.
//  PULSE: s[ch]=val, r[ch]=~val; all other bits of s,r = 0. GAP/IDLE: s=r=0.
//  Invariants every cycle: (s & r)==0; popcount(s|r)<=1.
//  state_q[ch] <= val at the edge ending the last PULSE cycle; other bits unchanged.
//  Out-of-range ch (ch>=N_CH): accepted, err=1 next cycle, no pulse, no gap; done with err.
//  Reset mid-PULSE/GAP: s,r drop to 0 at that edge; state_q cleared (model lost, by design).
//  busy = FSM!=IDLE; done and err never high in same cycle as s|r.
// CONFIGURATION
//  SR_SKIP_REDUNDANT_EN defined: if req_val==state_q[ch] at accept, no pulse/gap; done=1 in
//   cycle 1 and FSM stays IDLE. Undefined: every valid command pulses, even if redundant.
// STRUCTURE
//  Package sr_pkg: typedef enum {IDLE,PULSE,GAP} sr_state_t; typedef struct {ch,val} sr_cmd_t.
//  Sub-module sr_cycle_counter: loadable down-counter with zero flag, shared by PULSE and GAP.
// TESTING
//  Reset hold 3 cycles -> s=r=0, state_q=0, req_ready=0; release -> req_ready=1 next cycle.
//  ch=2,val=1, P=2,G=1 -> s=4'b0100 cycles 1-2, zero cycle 3, done cycle 4; state_q=4'b0100.
//  Back-to-back ch=2 set then ch=2 reset, req_valid held -> second accepted in done cycle; r=4'b0100.
//  ch=5 with N_CH=4 -> err pulse, s=r=0 throughout, state_q unchanged.
//  rst_n low during cycle 1 of PULSE -> s=r=0 next cycle, state_q=0, FSM IDLE.
//  SR_SKIP_REDUNDANT_EN: set ch0 twice -> second: no s pulse, done next cycle; undefined: pulses.
//  Random stimulus assertion: (s&r)==0 and popcount(s|r)<=1 on every cycle.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared types for the SR pulse driver: FSM encoding, latched command and counter sizing.
// Channel indices are carried at SR_CH_W bits, so N_CH is limited to 2**SR_CH_W channels.
package sr_pkg;

  localparam int SR_CH_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } sr_state_t;

  typedef struct packed {
    logic [SR_CH_W-1:0] ch;
    logic               val;
  } sr_cmd_t;

  // Counter holds (length - 1) of the longer of the two phases.
  function automatic int sr_cnt_w(input int pulse_cycles, input int gap_cycles);
    int m;
    m = (pulse_cycles > gap_cycles) ? pulse_cycles : gap_cycles;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sr_cycle_counter.sv
// Loadable down-counter with a zero flag; it times both the PULSE and the GAP phase.
// It holds at zero rather than wrapping, so a stray decrement is harmless.
module sr_cycle_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sr_pulse_driver.sv
// Turns (channel, value) write requests into exclusive set/reset pulses with a guard gap.
// Optional SR_SKIP_REDUNDANT_EN: commands matching the tracked flop state complete without a pulse.
module sr_pulse_driver
  import sr_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  localparam int CW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [CW-1:0]   req_ch,
  input  logic            req_val,
  output logic [N_CH-1:0] s,
  output logic [N_CH-1:0] r,
  output logic [N_CH-1:0] state_q,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int               CNT_W    = sr_cnt_w(PULSE_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sr_state_t        fsm_q, fsm_d;
  sr_cmd_t          cmd_q, cmd_d;
  logic [N_CH-1:0]  track_q, track_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             accept;
  logic             req_oor;
  logic             req_redundant;

  sr_cycle_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  assign accept  = req_valid & req_ready;
  assign req_oor = (32'(req_ch) >= N_CH);

`ifdef SR_SKIP_REDUNDANT_EN
  always_comb begin
    req_redundant = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if ((32'(req_ch) == i) && (track_q[i] == req_val)) begin
        req_redundant = 1'b1;
      end
    end
  end
`else
  assign req_redundant = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      track_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      track_q <= track_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // The latched command is only read while the FSM is out of IDLE, so it needs no reset.
  always_ff @(posedge clk) begin
    cmd_q <= cmd_d;
  end

  always_comb begin
    fsm_d        = fsm_q;
    cmd_d        = cmd_q;
    track_d      = track_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = PULSE_LD;
    cnt_dec      = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          cmd_d.ch  = SR_CH_W'(req_ch);
          cmd_d.val = req_val;
          if (req_oor) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if (req_redundant) begin
            done_d = 1'b1;
          end else begin
            fsm_d    = PULSE;
            cnt_load = 1'b1;
          end
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          for (int i = 0; i < N_CH; i++) begin
            if (cmd_q.ch == SR_CH_W'(i)) begin
              track_d[i] = cmd_q.val;
            end
          end
          if (GAP_CYCLES > 0) begin
            fsm_d        = GAP;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LD;
          end else begin
            fsm_d  = IDLE;
            done_d = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (cnt_zero) begin
          fsm_d  = IDLE;
          done_d = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Only the addressed channel is ever driven, and only one of its s/r lines.
  always_comb begin
    s = '0;
    r = '0;
    if (fsm_q == PULSE) begin
      for (int i = 0; i < N_CH; i++) begin
        if (cmd_q.ch == SR_CH_W'(i)) begin
          s[i] = cmd_q.val;
          r[i] = ~cmd_q.val;
        end
      end
    end
  end

  assign req_ready = (fsm_q == IDLE) & rst_n;
  assign busy      = (fsm_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign state_q   = track_q;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Bench for sr_pulse_driver: directed scenarios then random traffic, checked against a
// schedule-based reference that plans each command's outputs from its accept cycle.
module tb_sr_pulse_driver;

  localparam int N_CH = 5;
  localparam int P    = 2;
  localparam int G    = 1;
  localparam int CW   = 3;
  localparam int NCYC = 1700;
  localparam int HORZ = P + G + 4;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [CW-1:0]   req_ch;
  logic            req_val;
  logic [N_CH-1:0] s;
  logic [N_CH-1:0] r;
  logic [N_CH-1:0] state_q;
  logic            busy;
  logic            done;
  logic            err;

  sr_pulse_driver #(
    .N_CH(N_CH),
    .PULSE_CYCLES(P),
    .GAP_CYCLES(G)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_ch   (req_ch),
    .req_val  (req_val),
    .s        (s),
    .r        (r),
    .state_q  (state_q),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: per-cycle expected outputs planned at accept time.
  logic [N_CH-1:0] exp_s    [0:NCYC+HORZ];
  logic [N_CH-1:0] exp_r    [0:NCYC+HORZ];
  logic            exp_done [0:NCYC+HORZ];
  logic            exp_err  [0:NCYC+HORZ];
  logic [N_CH-1:0] mdl_state;
  int              free_at;
  int              pend_at;
  int              pend_ch;
  logic            pend_val;
  int              cyc;
  bit              chk_en;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic [N_CH-1:0] sr_or;
    if (pend_at == cyc) begin
      mdl_state[pend_ch] = pend_val;
      pend_at = -1;
    end
    if (chk_en) begin
      sr_or = s | r;
      check_eq("s", 32'(s), 32'(exp_s[cyc]));
      check_eq("r", 32'(r), 32'(exp_r[cyc]));
      check_eq("state_q", 32'(state_q), 32'(mdl_state));
      check_eq("done", 32'(done), 32'(exp_done[cyc]));
      check_eq("err", 32'(err), 32'(exp_err[cyc]));
      check_eq("busy", 32'(busy), 32'(cyc < free_at));
      check_eq("req_ready", 32'(req_ready), 32'((cyc >= free_at) && rst_n));
      check_eq("excl", 32'(((s & r) == '0) && ($countones(sr_or) <= 1)), 32'd1);
    end
  endtask

  task automatic model_edge(input logic v, input int ch, input logic val, input logic rn);
    bit skip;
    if (!rn) begin
      for (int k = cyc + 1; k <= cyc + HORZ; k++) begin
        exp_s[k] = '0; exp_r[k] = '0; exp_done[k] = 1'b0; exp_err[k] = 1'b0;
      end
      mdl_state = '0;
      pend_at   = -1;
      free_at   = cyc + 1;
      chk_en    = 1'b1;
    end else if (v && (cyc >= free_at)) begin
      skip = 1'b0;
`ifdef SR_SKIP_REDUNDANT_EN
      if (ch < N_CH) skip = (mdl_state[ch] == val);
`endif
      if (ch >= N_CH) begin
        exp_err[cyc+1]  = 1'b1;
        exp_done[cyc+1] = 1'b1;
        free_at = cyc + 1;
      end else if (skip) begin
        exp_done[cyc+1] = 1'b1;
        free_at = cyc + 1;
      end else begin
        for (int k = 1; k <= P; k++) begin
          exp_s[cyc+k] = val ? (N_CH'(1) << ch) : '0;
          exp_r[cyc+k] = val ? '0 : (N_CH'(1) << ch);
        end
        pend_at  = cyc + P + 1;
        pend_ch  = ch;
        pend_val = val;
        exp_done[cyc+P+G+1] = 1'b1;
        free_at = cyc + P + G + 1;
      end
    end
  endtask

  // One clock cycle: check the current cycle, drive inputs for the next edge, advance the model.
  task automatic tick(input logic v, input int ch, input logic val, input logic rn);
    @(negedge clk);
    check_cycle();
    req_valid = v;
    req_ch    = CW'(ch);
    req_val   = val;
    rst_n     = rn;
    model_edge(v, ch, val, rn);
    cyc++;
    @(posedge clk);
  endtask

  initial begin
    for (int k = 0; k <= NCYC + HORZ; k++) begin
      exp_s[k] = '0; exp_r[k] = '0; exp_done[k] = 1'b0; exp_err[k] = 1'b0;
    end
    mdl_state = '0;
    free_at   = 0;
    pend_at   = -1;
    pend_ch   = 0;
    pend_val  = 1'b0;
    cyc       = 0;
    chk_en    = 1'b0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_ch    = '0;
    req_val   = 1'b0;

    repeat (3) tick(1'b0, 0, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b1);
    // ch2 set, then ch2 reset held until accepted back-to-back in the done cycle
    tick(1'b1, 2, 1'b1, 1'b1);
    repeat (8) tick(1'b1, 2, 1'b0, 1'b1);
    repeat (2) tick(1'b0, 0, 1'b0, 1'b1);
    // out-of-range channel
    tick(1'b1, 5, 1'b1, 1'b1);
    repeat (3) tick(1'b0, 0, 1'b0, 1'b1);
    // set ch0 twice
    tick(1'b1, 0, 1'b1, 1'b1);
    repeat (8) tick(1'b1, 0, 1'b1, 1'b1);
    tick(1'b0, 0, 1'b0, 1'b1);
    // reset during the first PULSE cycle
    tick(1'b1, 1, 1'b1, 1'b1);
    tick(1'b0, 0, 1'b0, 1'b0);
    repeat (3) tick(1'b0, 0, 1'b0, 1'b1);

    while (cyc < NCYC - 2) begin
      tick(1'b1 & ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) != 0));
    end
    tick(1'b0, 0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
